// File: rtl/dynamic_bias_pkg.sv
// Shared types, default parameters and helpers for the multi-channel dynamic-bias controller.
// Optional build macro: DYN_BIAS_SAT_CNT_EN (per-channel clamp-cycle counter).
package dynamic_bias_pkg;

    typedef enum logic [1:0] {
        SETTLED = 2'd0,
        SLEW_UP = 2'd1,
        SLEW_DN = 2'd2
    } slew_state_e;

    localparam int NCH_DEF       = 4;
    localparam int IW_DEF        = 8;
    localparam int CW_DEF        = 8;
    localparam int VD_FRAC_DEF   = 7;
    localparam int GAIN_Q_DEF    = 29;
    localparam int GAIN_FRAC_DEF = 4;
    localparam int GW_DEF        = 8;
    localparam int IMAX_DEF      = 160;
    localparam int STEP_UP_DEF   = 8;
    localparam int STEP_DN_DEF   = 4;
    localparam int DLY_DEF       = 3;

    // Unsigned ceiling: returns value limited to max.
    function automatic logic [31:0] clamp_u(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/dyn_bias_ch.sv
// One bias channel: vd-scaled target, IMAX clamp, transport delay, asymmetric slew FSM.
// Optional build macro: DYN_BIAS_SAT_CNT_EN adds o_sat_cnt.
module dyn_bias_ch
    import dynamic_bias_pkg::*;
#(
    parameter int IW        = IW_DEF,
    parameter int CW        = CW_DEF,
    parameter int VD_FRAC   = VD_FRAC_DEF,
    parameter int GAIN_Q    = GAIN_Q_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF,
    parameter int GW        = GW_DEF,
    parameter int IMAX      = IMAX_DEF,
    parameter int STEP_UP   = STEP_UP_DEF,
    parameter int STEP_DN   = STEP_DN_DEF,
    parameter int DLY       = DLY_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_mode,
    input  logic          i_upd,
    input  logic [IW-1:0] i_iin,
    input  logic [CW-1:0] i_vd,
    output logic [GW-1:0] o_iout,
    output logic          o_settled,
    output logic          o_clamped
`ifdef DYN_BIAS_SAT_CNT_EN
    ,output logic [15:0]  o_sat_cnt
`endif
);

    localparam int GQW = $clog2(GAIN_Q + 1);
    localparam int PW  = IW + CW + GQW;
    localparam int SH  = VD_FRAC + GAIN_FRAC;

    logic [PW-1:0] w_prod_p0;
    logic [PW-1:0] w_raw_p0;
    logic [GW-1:0] w_tgt_p0;
    logic          w_sat_p0;
    logic [GW-1:0] r_tgt_p1;
    logic          r_clamped_p1;
    logic [GW-1:0] w_dtgt;
    logic [GW-1:0] r_iout;
    logic [GW-1:0] w_iout_nxt;
    logic [GW-1:0] w_diff;
    slew_state_e   r_state;
    slew_state_e   w_state_nxt;

    // Stage p0: full-width product, truncating shift, static bypass and ceiling
    always_comb begin
        w_prod_p0 = PW'(i_iin) * PW'(i_vd) * PW'(GAIN_Q);
        w_raw_p0  = i_mode ? PW'(i_iin) : (w_prod_p0 >> SH);
        w_tgt_p0  = GW'(clamp_u(32'(w_raw_p0), 32'(IMAX)));
        w_sat_p0  = (w_raw_p0 > PW'(IMAX));
    end

    // Stage p1: target register; disable wins over a simultaneous update strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt_p1     <= '0;
            r_clamped_p1 <= 1'b0;
        end else if (!i_en) begin
            r_tgt_p1     <= '0;
            r_clamped_p1 <= 1'b0;
        end else if (i_upd) begin
            r_tgt_p1     <= w_tgt_p0;
            r_clamped_p1 <= w_sat_p0;
        end
    end

    // Stage p2: transport delay of the registered target
    generate
        if (DLY == 0) begin : g_nodly
            assign w_dtgt = r_tgt_p1;
        end else begin : g_dly
            logic [GW-1:0] r_dly_p2 [DLY];
            // Shift the target one place per cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DLY; k++) r_dly_p2[k] <= '0;
                end else begin
                    r_dly_p2[0] <= r_tgt_p1;
                    for (int k = 1; k < DLY; k++) r_dly_p2[k] <= r_dly_p2[k-1];
                end
            end
            assign w_dtgt = r_dly_p2[DLY-1];
        end
    endgenerate

    // Slew FSM state and output code register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SETTLED;
            r_iout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_iout  <= w_iout_nxt;
        end
    end

    // Slew step toward the delayed target; the last step is trimmed to land exactly
    always_comb begin
        w_state_nxt = SETTLED;
        w_iout_nxt  = r_iout;
        w_diff      = '0;
        if (w_dtgt > r_iout) begin
            w_diff      = w_dtgt - r_iout;
            w_iout_nxt  = r_iout + ((w_diff > GW'(STEP_UP)) ? GW'(STEP_UP) : w_diff);
            w_state_nxt = SLEW_UP;
        end else if (w_dtgt < r_iout) begin
            w_diff      = r_iout - w_dtgt;
            w_iout_nxt  = r_iout - ((w_diff > GW'(STEP_DN)) ? GW'(STEP_DN) : w_diff);
            w_state_nxt = SLEW_DN;
        end
    end

    // The recorded direction must agree with where the code sits relative to the previous target
    a_slew_dir: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |->
            ((r_state == SETTLED) && (r_iout == $past(w_dtgt))) ||
            ((r_state == SLEW_UP) && (r_iout <= $past(w_dtgt))) ||
            ((r_state == SLEW_DN) && (r_iout >= $past(w_dtgt))));

    assign o_iout    = r_iout;
    assign o_settled = (r_iout == w_dtgt);
    assign o_clamped = r_clamped_p1;

`ifdef DYN_BIAS_SAT_CNT_EN
    logic [15:0] r_sat_cnt;
    // Count cycles spent at the ceiling; an update taken while disabled clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (i_upd && !i_en) begin
            r_sat_cnt <= '0;
        end else if (r_clamped_p1 && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end
    assign o_sat_cnt = r_sat_cnt;
`endif

endmodule

// File: rtl/dynamic_bias_mc.sv
// NCH-channel clocked dynamic-bias controller: packs/unpacks buses around dyn_bias_ch.
// Optional build macro: DYN_BIAS_SAT_CNT_EN adds the packed sat_cnt output.
module dynamic_bias_mc
    import dynamic_bias_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int IW        = IW_DEF,
    parameter int CW        = CW_DEF,
    parameter int VD_FRAC   = VD_FRAC_DEF,
    parameter int GAIN_Q    = GAIN_Q_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF,
    parameter int GW        = GW_DEF,
    parameter int IMAX      = IMAX_DEF,
    parameter int STEP_UP   = STEP_UP_DEF,
    parameter int STEP_DN   = STEP_DN_DEF,
    parameter int DLY       = DLY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    mode,
    input  logic              upd,
    input  logic [NCH*IW-1:0] iin_code,
    input  logic [NCH*CW-1:0] vd_code,
    output logic [NCH*GW-1:0] iout,
    output logic [NCH-1:0]    settled,
    output logic [NCH-1:0]    clamped
`ifdef DYN_BIAS_SAT_CNT_EN
    ,output logic [NCH*16-1:0] sat_cnt
`endif
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dyn_bias_ch #(
            .IW        (IW),
            .CW        (CW),
            .VD_FRAC   (VD_FRAC),
            .GAIN_Q    (GAIN_Q),
            .GAIN_FRAC (GAIN_FRAC),
            .GW        (GW),
            .IMAX      (IMAX),
            .STEP_UP   (STEP_UP),
            .STEP_DN   (STEP_DN),
            .DLY       (DLY)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en[g]),
            .i_mode    (mode[g]),
            .i_upd     (upd),
            .i_iin     (iin_code[g*IW +: IW]),
            .i_vd      (vd_code[g*CW +: CW]),
            .o_iout    (iout[g*GW +: GW]),
            .o_settled (settled[g]),
            .o_clamped (clamped[g])
`ifdef DYN_BIAS_SAT_CNT_EN
            ,.o_sat_cnt (sat_cnt[g*16 +: 16])
`endif
        );
    end

endmodule
